// File: rtl/back_pressure_gen.sv
// back_pressure_gen: per-channel AXI-Stream tready generator with transfer/stall statistics.
//
// Each of NUM_CH sink channels gets a registered tready driven from one of four modes:
//   0 ALWAYS          - ready every cycle
//   1 PERIODIC        - cfg_on_cycles ready, cfg_off_cycles not ready, repeating (lockstep)
//   2 RANDOM          - ready when the channel LFSR low byte is below cfg_prob
//   3 POST_XFER_STALL - ready until a handshake, then cfg_off_cycles not ready
//
// Ports:
//   aclk, arst       clock, asynchronous active-high reset
//   cfg_en           0 forces tready low, parks the FSMs in ON and holds the LFSRs
//   cfg_mode         mode select (see above)
//   cfg_on_cycles    PERIODIC ready-phase length
//   cfg_off_cycles   PERIODIC not-ready length / POST_XFER_STALL stall length
//   cfg_prob         RANDOM ready threshold out of 256
//   stat_clr         synchronous clear of all statistics (wins over a same-cycle event)
//   tvalid           per-channel valid from the DUT
//   tready           per-channel ready to the DUT (registered)
//   xfer_cnt         saturating handshake counts, channel i at [i*CNT_W +: CNT_W]
//   stall_cnt        saturating tvalid & ~tready counts, same packing
module back_pressure_gen #(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned CNT_W     = 16,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                    aclk,
    input  logic                    arst,
    input  logic                    cfg_en,
    input  logic [1:0]              cfg_mode,
    input  logic [CNT_W-1:0]        cfg_on_cycles,
    input  logic [CNT_W-1:0]        cfg_off_cycles,
    input  logic [7:0]              cfg_prob,
    input  logic                    stat_clr,
    input  logic [NUM_CH-1:0]       tvalid,
    output logic [NUM_CH-1:0]       tready,
    output logic [NUM_CH*CNT_W-1:0] xfer_cnt,
    output logic [NUM_CH*CNT_W-1:0] stall_cnt
);

    localparam logic [1:0]       ModeAlways   = 2'd0;
    localparam logic [1:0]       ModePeriodic = 2'd1;
    localparam logic [1:0]       ModeRandom   = 2'd2;
    localparam logic [1:0]       ModePostXfer = 2'd3;
    localparam logic [15:0]      LfsrTaps     = 16'hB400;
    localparam logic [CNT_W-1:0] CntMax       = {CNT_W{1'b1}};

    typedef enum logic [1:0] {StOn, StOff, StStall} state_e;

    // Copy of the previous cycle's configuration; any difference restarts the FSMs in ON.
    logic [1:0]       mode_q;
    logic [CNT_W-1:0] on_q;
    logic [CNT_W-1:0] off_q;
    logic [7:0]       prob_q;
    logic             cfg_chg;
    logic             on_zero;
    logic             off_zero;

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            mode_q <= 2'd0;
            on_q   <= '0;
            off_q  <= '0;
            prob_q <= 8'd0;
        end else begin
            mode_q <= cfg_mode;
            on_q   <= cfg_on_cycles;
            off_q  <= cfg_off_cycles;
            prob_q <= cfg_prob;
        end
    end

    assign cfg_chg  = {cfg_mode, cfg_on_cycles, cfg_off_cycles, cfg_prob}
                      != {mode_q, on_q, off_q, prob_q};
    assign on_zero  = (cfg_on_cycles == '0);
    assign off_zero = (cfg_off_cycles == '0);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        localparam logic [15:0] SeedRaw = LFSR_SEED ^ 16'(i + 1);
        localparam logic [15:0] Seed    = (SeedRaw == 16'h0000) ? 16'h0001 : SeedRaw;

        state_e           state_q;
        state_e           st_eff;
        logic [CNT_W-1:0] phase_q;
        logic [CNT_W-1:0] ph_eff;
        logic [CNT_W:0]   ph_inc;
        logic [15:0]      lfsr_q;
        logic [15:0]      lfsr_nxt;
        logic             ready_q;
        logic             hs;
        logic             stl;
        logic             per_on;
        logic [CNT_W-1:0] xfer_q;
        logic [CNT_W-1:0] stall_q;

        assign st_eff   = cfg_chg ? StOn : state_q;
        assign ph_eff   = cfg_chg ? '0 : phase_q;
        assign ph_inc   = {1'b0, ph_eff} + (CNT_W + 1)'(1);
        assign lfsr_nxt = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LfsrTaps : 16'h0000);
        assign hs       = tvalid[i] & ready_q;
        assign stl      = tvalid[i] & ~ready_q;

        // A zero-length phase is skipped: on=0 pins OFF, off=0 pins ON (off=0 wins).
        assign per_on = (st_eff == StOn) ? (!on_zero || off_zero) : off_zero;

        always_ff @(posedge aclk or posedge arst) begin
            if (arst) begin
                state_q <= StOn;
                phase_q <= '0;
                lfsr_q  <= Seed;
                ready_q <= 1'b0;
            end else if (!cfg_en) begin
                state_q <= StOn;
                phase_q <= '0;
                ready_q <= 1'b0;
            end else begin
                lfsr_q <= lfsr_nxt;
                unique case (cfg_mode)
                    ModeAlways: begin
                        state_q <= StOn;
                        phase_q <= '0;
                        ready_q <= 1'b1;
                    end
                    ModeRandom: begin
                        state_q <= StOn;
                        phase_q <= '0;
                        ready_q <= (lfsr_q[7:0] < cfg_prob);
                    end
                    ModePeriodic: begin
                        // phase counts cycles already emitted in the current state
                        if (per_on) begin
                            ready_q <= 1'b1;
                            if (off_zero) begin
                                state_q <= StOn;
                                phase_q <= '0;
                            end else if (ph_inc >= {1'b0, cfg_on_cycles}) begin
                                state_q <= StOff;
                                phase_q <= '0;
                            end else begin
                                state_q <= StOn;
                                phase_q <= ph_inc[CNT_W-1:0];
                            end
                        end else begin
                            ready_q <= 1'b0;
                            if (on_zero) begin
                                state_q <= StOff;
                                phase_q <= '0;
                            end else if (ph_inc >= {1'b0, cfg_off_cycles}) begin
                                state_q <= StOn;
                                phase_q <= '0;
                            end else begin
                                state_q <= StOff;
                                phase_q <= ph_inc[CNT_W-1:0];
                            end
                        end
                    end
                    ModePostXfer: begin
                        if (st_eff == StOn) begin
                            if (hs && !off_zero) begin
                                // the zero emitted on this edge is the first stall cycle
                                state_q <= StStall;
                                phase_q <= CNT_W'(1);
                                ready_q <= 1'b0;
                            end else begin
                                state_q <= StOn;
                                phase_q <= '0;
                                ready_q <= 1'b1;
                            end
                        end else if (ph_eff >= cfg_off_cycles) begin
                            state_q <= StOn;
                            phase_q <= '0;
                            ready_q <= 1'b1;
                        end else begin
                            state_q <= StStall;
                            phase_q <= ph_inc[CNT_W-1:0];
                            ready_q <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= StOn;
                        phase_q <= '0;
                        ready_q <= 1'b0;
                    end
                endcase
            end
        end

        always_ff @(posedge aclk or posedge arst) begin
            if (arst) begin
                xfer_q  <= '0;
                stall_q <= '0;
            end else if (stat_clr) begin
                xfer_q  <= '0;
                stall_q <= '0;
            end else begin
                if (hs && (xfer_q != CntMax)) begin
                    xfer_q <= xfer_q + CNT_W'(1);
                end
                if (stl && (stall_q != CntMax)) begin
                    stall_q <= stall_q + CNT_W'(1);
                end
            end
        end

        assign tready[i]                    = ready_q;
        assign xfer_cnt[i*CNT_W +: CNT_W]  = xfer_q;
        assign stall_cnt[i*CNT_W +: CNT_W] = stall_q;
    end

endmodule

// File: tb/tb_back_pressure_gen.sv
module tb_back_pressure_gen;

    localparam int NCH = 4;

    logic        aclk     = 1'b0;
    logic        arst     = 1'b1;
    logic        cfg_en   = 1'b0;
    logic [1:0]  cfg_mode = 2'd0;
    logic [15:0] cfg_on   = 16'd0;
    logic [15:0] cfg_off  = 16'd0;
    logic [7:0]  cfg_prob = 8'd0;
    logic        stat_clr = 1'b0;
    logic [3:0]  tvalid   = 4'd0;

    logic [3:0]  tready_b;
    logic [63:0] xfer_b;
    logic [63:0] stall_b;
    logic [3:0]  tready_s;
    logic [15:0] xfer_s;
    logic [15:0] stall_s;

    int checks   = 0;
    int failures = 0;

    always #5 aclk = ~aclk;

    back_pressure_gen #(.NUM_CH(4), .CNT_W(16), .LFSR_SEED(16'hACE1)) u_big (
        .aclk           (aclk),
        .arst           (arst),
        .cfg_en         (cfg_en),
        .cfg_mode       (cfg_mode),
        .cfg_on_cycles  (cfg_on),
        .cfg_off_cycles (cfg_off),
        .cfg_prob       (cfg_prob),
        .stat_clr       (stat_clr),
        .tvalid         (tvalid),
        .tready         (tready_b),
        .xfer_cnt       (xfer_b),
        .stall_cnt      (stall_b)
    );

    back_pressure_gen #(.NUM_CH(4), .CNT_W(4), .LFSR_SEED(16'hACE1)) u_small (
        .aclk           (aclk),
        .arst           (arst),
        .cfg_en         (cfg_en),
        .cfg_mode       (cfg_mode),
        .cfg_on_cycles  (cfg_on[3:0]),
        .cfg_off_cycles (cfg_off[3:0]),
        .cfg_prob       (cfg_prob),
        .stat_clr       (stat_clr),
        .tvalid         (tvalid),
        .tready         (tready_s),
        .xfer_cnt       (xfer_s),
        .stall_cnt      (stall_s)
    );

    // ---------------- reference model ----------------
    // Ready is derived from the mode rules directly: PERIODIC from a cycle index modulo the
    // period, POST_XFER_STALL from a remaining-stall count, RANDOM from a stepped LFSR.
    logic [3:0]  m_ready;
    logic [3:0]  m_nr;
    int          m_x [NCH];
    int          m_s [NCH];
    logic [15:0] m_lfsr [NCH];
    int          m_rem [NCH];
    int          m_k;
    bit          m_restart;
    logic [1:0]  p_mode;
    logic [15:0] p_on;
    logic [15:0] p_off;
    logic [7:0]  p_prob;

    function automatic logic [15:0] seed_of(input int ch);
        logic [15:0] s;
        s = 16'hACE1 ^ 16'(ch + 1);
        return (s == 16'h0000) ? 16'h0001 : s;
    endfunction

    function automatic bit per_ready(input int k, input int on, input int off);
        if (off == 0) return 1'b1;
        if (on == 0) return 1'b0;
        return (k % (on + off)) < on;
    endfunction

    function automatic int sat(input int v, input int m);
        return (v > m) ? m : v;
    endfunction

    always @(posedge aclk or posedge arst) begin
        if (arst) begin
            m_ready = 4'd0;
            m_k     = 0;
            p_mode  = 2'd0;
            p_on    = 16'd0;
            p_off   = 16'd0;
            p_prob  = 8'd0;
            for (int ch = 0; ch < NCH; ch++) begin
                m_x[ch]    = 0;
                m_s[ch]    = 0;
                m_rem[ch]  = 0;
                m_lfsr[ch] = seed_of(ch);
            end
        end else begin
            for (int ch = 0; ch < NCH; ch++) begin
                if (stat_clr) begin
                    m_x[ch] = 0;
                    m_s[ch] = 0;
                end else begin
                    if (tvalid[ch] && m_ready[ch]) m_x[ch] = m_x[ch] + 1;
                    if (tvalid[ch] && !m_ready[ch]) m_s[ch] = m_s[ch] + 1;
                end
            end
            m_restart = !cfg_en || (cfg_mode != p_mode) || (cfg_on != p_on) ||
                        (cfg_off != p_off) || (cfg_prob != p_prob);
            p_mode = cfg_mode;
            p_on   = cfg_on;
            p_off  = cfg_off;
            p_prob = cfg_prob;
            if (m_restart) begin
                m_k = 0;
                for (int ch = 0; ch < NCH; ch++) m_rem[ch] = 0;
            end
            m_nr = 4'd0;
            if (cfg_en) begin
                case (cfg_mode)
                    2'd0: m_nr = 4'hF;
                    2'd1: begin
                        for (int ch = 0; ch < NCH; ch++)
                            m_nr[ch] = per_ready(m_k, int'(cfg_on), int'(cfg_off));
                        m_k = m_k + 1;
                    end
                    2'd2: begin
                        for (int ch = 0; ch < NCH; ch++)
                            m_nr[ch] = (m_lfsr[ch][7:0] < cfg_prob);
                    end
                    default: begin
                        for (int ch = 0; ch < NCH; ch++) begin
                            if (tvalid[ch] && m_ready[ch] && cfg_off != 16'd0)
                                m_rem[ch] = int'(cfg_off);
                            if (m_rem[ch] > 0) begin
                                m_nr[ch]  = 1'b0;
                                m_rem[ch] = m_rem[ch] - 1;
                            end else begin
                                m_nr[ch] = 1'b1;
                            end
                        end
                    end
                endcase
                for (int ch = 0; ch < NCH; ch++)
                    m_lfsr[ch] = {1'b0, m_lfsr[ch][15:1]} ^
                                 (m_lfsr[ch][0] ? 16'hB400 : 16'h0000);
            end
            m_ready = m_nr;
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic compare_model();
        logic [63:0] ebx, ebs;
        logic [15:0] esx, ess;
        for (int ch = 0; ch < NCH; ch++) begin
            ebx[ch*16 +: 16] = 16'(sat(m_x[ch], 65535));
            ebs[ch*16 +: 16] = 16'(sat(m_s[ch], 65535));
            esx[ch*4 +: 4]   = 4'(sat(m_x[ch], 15));
            ess[ch*4 +: 4]   = 4'(sat(m_s[ch], 15));
        end
        chk("mdl_tready_big", 64'(tready_b), 64'(m_ready));
        chk("mdl_tready_small", 64'(tready_s), 64'(m_ready));
        chk("mdl_xfer_big", xfer_b, ebx);
        chk("mdl_stall_big", stall_b, ebs);
        chk("mdl_xfer_small", 64'(xfer_s), 64'(esx));
        chk("mdl_stall_small", 64'(stall_s), 64'(ess));
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
        compare_model();
    endtask

    // assert reset away from the clock edge and check it takes effect before the next edge
    task automatic async_reset(input string name);
        #2 arst = 1'b1;
        #1;
        chk({name, "_tready"}, 64'(tready_b), 64'd0);
        chk({name, "_xfer"}, xfer_b, 64'd0);
        chk({name, "_stall"}, stall_b, 64'd0);
        @(posedge aclk);
        @(posedge aclk);
        #4 arst = 1'b0;
    endtask

    typedef struct {
        logic       en;
        logic [1:0] mode;
        logic [3:0] on;
        logic [3:0] off;
        logic [7:0] prob;
        logic [3:0] tv;
        logic [3:0] tr;
        int         x0;
        int         s0;
    } vec_t;

    vec_t tbl [17];
    int   rcnt [NCH];
    bit   differ [NCH];
    logic [11:0] pxs_pat;
    logic [8:0]  per_pat;

    initial begin
        //           en    mode  on    off   prob  tv     tready x0 s0
        tbl[0]  = '{1'b1, 2'd0, 4'd0, 4'd0, 8'd0, 4'hF, 4'hF, 0, 1};
        tbl[1]  = '{1'b1, 2'd0, 4'd0, 4'd0, 8'd0, 4'hF, 4'hF, 1, 1};
        tbl[2]  = '{1'b0, 2'd0, 4'd0, 4'd0, 8'd0, 4'hF, 4'h0, 2, 1};
        tbl[3]  = '{1'b1, 2'd1, 4'd2, 4'd1, 8'd0, 4'h0, 4'hF, 2, 1};
        tbl[4]  = '{1'b1, 2'd1, 4'd2, 4'd1, 8'd0, 4'h0, 4'hF, 2, 1};
        tbl[5]  = '{1'b1, 2'd1, 4'd2, 4'd1, 8'd0, 4'h0, 4'h0, 2, 1};
        tbl[6]  = '{1'b1, 2'd1, 4'd2, 4'd1, 8'd0, 4'h0, 4'hF, 2, 1};
        tbl[7]  = '{1'b1, 2'd1, 4'd0, 4'd3, 8'd0, 4'h0, 4'h0, 2, 1};
        tbl[8]  = '{1'b1, 2'd1, 4'd0, 4'd3, 8'd0, 4'h0, 4'h0, 2, 1};
        tbl[9]  = '{1'b1, 2'd1, 4'd2, 4'd0, 8'd0, 4'h0, 4'hF, 2, 1};
        tbl[10] = '{1'b1, 2'd2, 4'd2, 4'd0, 8'd0, 4'h0, 4'h0, 2, 1};
        tbl[11] = '{1'b1, 2'd2, 4'd2, 4'd0, 8'd0, 4'h0, 4'h0, 2, 1};
        tbl[12] = '{1'b1, 2'd3, 4'd0, 4'd2, 8'd0, 4'hF, 4'hF, 2, 2};
        tbl[13] = '{1'b1, 2'd3, 4'd0, 4'd2, 8'd0, 4'hF, 4'h0, 3, 2};
        tbl[14] = '{1'b1, 2'd3, 4'd0, 4'd2, 8'd0, 4'hF, 4'h0, 3, 3};
        tbl[15] = '{1'b1, 2'd3, 4'd0, 4'd2, 8'd0, 4'hF, 4'hF, 3, 4};
        tbl[16] = '{1'b1, 2'd3, 4'd0, 4'd2, 8'd0, 4'h1, 4'hE, 4, 4};

        // power-on reset
        repeat (2) @(posedge aclk);
        #4 arst = 1'b0;
        #1;
        chk("reset_tready", 64'(tready_b), 64'd0);
        chk("reset_xfer", xfer_b, 64'd0);
        chk("reset_stall", stall_b, 64'd0);
        chk("reset_tready_small", 64'(tready_s), 64'd0);

        // table of single-cycle vectors
        for (int i = 0; i < 17; i++) begin
            cfg_en   = tbl[i].en;
            cfg_mode = tbl[i].mode;
            cfg_on   = 16'(tbl[i].on);
            cfg_off  = 16'(tbl[i].off);
            cfg_prob = tbl[i].prob;
            tvalid   = tbl[i].tv;
            tick();
            chk($sformatf("tbl%0d_tready", i), 64'(tready_b), 64'(tbl[i].tr));
            chk($sformatf("tbl%0d_xfer0", i), 64'(xfer_b[15:0]), 64'(tbl[i].x0));
            chk($sformatf("tbl%0d_stall0", i), 64'(stall_b[15:0]), 64'(tbl[i].s0));
        end

        // POST_XFER_STALL off=4 on channel 0 only, clearing stats on the first cycle
        pxs_pat  = 12'b010000100001;  // bit k = tready[0] after tick k
        cfg_mode = 2'd3;
        cfg_on   = 16'd0;
        cfg_off  = 16'd4;
        tvalid   = 4'b0001;
        stat_clr = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            stat_clr = 1'b0;
            chk($sformatf("pxs_ch0_t%0d", k), 64'(tready_b[0]), 64'(pxs_pat[k]));
            chk($sformatf("pxs_ch123_t%0d", k), 64'(tready_b[3:1]), 64'h7);
        end
        chk("pxs_xfer_ch1", 64'(xfer_b[31:16]), 64'd0);

        // saturation of the 4-bit counters, then clear against a live handshake
        cfg_mode = 2'd0;
        tvalid   = 4'hF;
        repeat (20) tick();
        chk("sat_xfer_small", 64'(xfer_s), 64'hFFFF);
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        chk("clr_xfer_big", xfer_b, 64'd0);
        chk("clr_xfer_small", 64'(xfer_s), 64'd0);
        chk("clr_stall_big", stall_b, 64'd0);
        tick();
        chk("post_clr_xfer_big", xfer_b, 64'h0001_0001_0001_0001);

        // RANDOM prob=0: never ready
        cfg_mode = 2'd2;
        cfg_prob = 8'd0;
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        for (int k = 0; k < 50; k++) begin
            tick();
            chk($sformatf("prob0_tready_t%0d", k), 64'(tready_b), 64'd0);
        end
        chk("prob0_stall", stall_b, 64'h0032_0032_0032_0032);

        // RANDOM prob=128: roughly half ready, channels differ
        cfg_prob = 8'd128;
        for (int ch = 0; ch < NCH; ch++) begin
            rcnt[ch]   = 0;
            differ[ch] = 1'b0;
        end
        for (int k = 0; k < 4096; k++) begin
            tick();
            for (int ch = 0; ch < NCH; ch++) begin
                if (tready_b[ch]) rcnt[ch]++;
                if (tready_b[ch] != tready_b[0]) differ[ch] = 1'b1;
            end
        end
        for (int ch = 0; ch < NCH; ch++) begin
            checks++;
            if (rcnt[ch] < 1843 || rcnt[ch] > 2252) begin
                failures++;
                $display("FAIL rand_frac ch%0d actual=%0d required=1843..2252", ch, rcnt[ch]);
            end
        end
        for (int ch = 1; ch < NCH; ch++)
            chk($sformatf("rand_distinct_ch%0d", ch), 64'(differ[ch]), 64'd1);

        // reset in the PERIODIC OFF phase, then ON restarts from the release
        per_pat  = 9'b100000111;
        cfg_mode = 2'd1;
        cfg_on   = 16'd3;
        cfg_off  = 16'd5;
        repeat (5) tick();
        chk("pre_rst_off", 64'(tready_b), 64'd0);
        async_reset("rst_off");
        for (int k = 0; k < 9; k++) begin
            tick();
            chk($sformatf("rst_per_t%0d", k), 64'(tready_b), per_pat[k] ? 64'hF : 64'h0);
        end

        // reset again and go straight to RANDOM: sequence must restart from the seeds
        async_reset("rst_rand");
        cfg_mode = 2'd2;
        cfg_prob = 8'd128;
        repeat (30) tick();

        // randomized segments against the model
        for (int seg = 0; seg < 60; seg++) begin
            int len;
            cfg_en   = ($urandom_range(0, 9) != 0);
            cfg_mode = 2'($urandom_range(0, 3));
            cfg_on   = 16'($urandom_range(0, 6));
            cfg_off  = 16'($urandom_range(0, 6));
            cfg_prob = 8'($urandom_range(0, 255));
            len      = int'($urandom_range(10, 60));
            for (int c = 0; c < len; c++) begin
                tvalid   = 4'($urandom);
                stat_clr = ($urandom_range(0, 49) == 0);
                tick();
            end
        end
        stat_clr = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/back_pressure_gen.md
Name: back_pressure_gen

Overview:
Parametrised per-channel AXI-Stream back-pressure generator for the verification environment. It drives tready for NUM_CH sink channels from one of four programmable modes and counts transfers and stall cycles per channel. It sits between the DUT master ports and the monitor and scoreboard, replacing fixed 4-channel tready stimulus.

Parameters:
NUM_CH, 4, number of independent stream channels
CNT_W, 16, width of the per-channel statistics counters and of the on/off cycle fields
LFSR_SEED, 16'hACE1, base seed for the per-channel random generators

Ports:
aclk  in  1  clock
arst  in  1  asynchronous active-high reset
cfg_en  in  1  generator enable; 0 forces all tready low and parks the state machines
cfg_mode  in  2  0=ALWAYS, 1=PERIODIC, 2=RANDOM, 3=POST_XFER_STALL
cfg_on_cycles  in  CNT_W  PERIODIC ready-phase length in cycles
cfg_off_cycles  in  CNT_W  PERIODIC not-ready length; POST_XFER_STALL stall length
cfg_prob  in  8  RANDOM ready threshold (out of 256)
stat_clr  in  1  synchronous clear of all statistics counters
tvalid  in  NUM_CH  per-channel valid from the DUT
tready  out  NUM_CH  per-channel ready to the DUT, registered
xfer_cnt  out  NUM_CH*CNT_W  per-channel handshake count; channel i occupies bits [i*CNT_W +: CNT_W]
stall_cnt  out  NUM_CH*CNT_W  per-channel count of cycles with tvalid=1 and tready=0; same packing

Behaviour:
- Reset (arst=1, asynchronous) sets:
  - tready=0, xfer_cnt=0, stall_cnt=0
  - phase counters=0, every channel FSM in ON
  - LFSR[i] = LFSR_SEED ^ (i+1); a zero result is replaced by 16'h0001
- Release of arst is taken synchronously to aclk.
- tready is a registered output. The value decided in cycle n appears in cycle n+1.
- Handshake on channel i: tvalid[i] & tready[i] sampled on the same rising edge.
- cfg_en=0:
  - tready=0
  - every FSM goes to ON with phase=0
  - LFSRs hold
  - statistics keep counting; stalls are counted because tready=0.
- Mode ALWAYS: tready=1 from the cycle after cfg_en is sampled high.
- Mode PERIODIC, per channel, two states ON and OFF:
  - ON: tready=1 for cfg_on_cycles cycles, then go to OFF.
  - OFF: tready=0 for cfg_off_cycles cycles, then go to ON.
  - Phases are independent of tvalid. All channels run in lockstep.
  - on=0 and off>0: tready stays 0.
  - off=0: tready stays 1.
  - on=0 and off=0: tready stays 1.
- Mode RANDOM:
  - Each channel has a 16-bit Galois LFSR, taps 16'hB400, advanced every cycle while cfg_en=1.
  - tready[i] next = (LFSR[i][7:0] < cfg_prob).
  - cfg_prob=0 gives tready always 0. cfg_prob=255 gives a ready probability of 255/256.
- Mode POST_XFER_STALL, per channel, states ON and STALL:
  - ON: tready=1.
  - A handshake in ON moves the channel to STALL with tready=0 for cfg_off_cycles cycles, then back to ON.
  - cfg_off_cycles=0: the channel stays in ON.
  - tvalid is ignored during STALL.
- Changing cfg_mode or any cfg field while cfg_en=1 takes effect on the next edge. Phase counters restart at 0 in ON.
- Statistics counters:
  - xfer_cnt[i] increments on a handshake.
  - stall_cnt[i] increments when tvalid[i]=1 and tready[i]=0.
  - Both saturate at 2^CNT_W-1 and do not wrap.
  - stat_clr=1 zeroes all counters on the next edge. It takes priority over a simultaneous increment, so that cycle's event is dropped.
- Reset asserted mid-operation returns every register to its reset value immediately. No partial state survives.
- Channels are fully independent apart from shared configuration.

Test Plan:
1. Reset, then cfg_en=1, mode=ALWAYS, tvalid=4'hF for 10 cycles -> tready=4'hF from the second edge; each xfer_cnt=9 or 10 per latency, stall_cnt=1.
2. mode=PERIODIC, on=3, off=2, tvalid=4'hF for 20 cycles -> tready pattern 11100 repeating on every channel; each xfer_cnt=12, stall_cnt=8 (including the first-cycle latency slot as specified).
3. mode=POST_XFER_STALL, off=4, tvalid[0]=1 continuously, other channels 0 -> tready[0] pattern 1,0,0,0,0,1 repeating; channels 1-3 stay at tready=1 with xfer_cnt=0.
4. mode=RANDOM: cfg_prob=0 for 50 cycles -> tready=0 throughout, stall_cnt=50. Then cfg_prob=128 for 4096 cycles -> per-channel xfer fraction within 45-55%, and channels are not identical (distinct seeds).
5. Saturation and clear with CNT_W=4, tvalid=1, mode=ALWAYS for 20 cycles -> xfer_cnt holds at 15. Pulse stat_clr in the same cycle as a handshake -> counter reads 0 next cycle.
6. Assert arst mid-PERIODIC OFF phase -> tready=0 and counters=0 asynchronously. After release, the ON phase restarts and the LFSRs equal their seed values.
